// File: rtl/ftoi_seq.sv
// rtl/ftoi_seq.sv - multi-cycle IEEE-754 single to signed 32-bit integer converter
// Iterative STEP-bit aligner, round to nearest-even, saturating with an overflow flag.
module ftoi_seq #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        ovf
);

    generate
        if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8)) begin : g_bad_step
            $error("ftoi_seq: STEP must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam logic [4:0] STEP5 = 5'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, OUT} state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [31:0] mag_q, mag_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic [4:0]  rem_q, rem_d;
    logic        left_q, left_d;
    logic [31:0] res_q, res_d;
    logic        ovf_q, ovf_d;

    logic        accept_w;
    logic [7:0]  exp_w;
    logic [22:0] frac_w;
    logic        sp_w;
    logic [31:0] sp_res_w;
    logic        sp_ovf_w;
    logic [4:0]  k_w;
    logic [31:0] sh_mag_w;
    logic        sh_guard_w;
    logic        sh_sticky_w;
    logic [4:0]  amt_w;
    logic [31:0] rnd_mag_w;

    assign accept_w = in_valid && in_ready;
    assign exp_w    = a[30:23];
    assign frac_w   = a[22:0];

    // Exponents 126..157 (E = -1..30) take the shifter; everything else resolves at once.
    always_comb begin
        sp_w     = 1'b1;
        sp_res_w = 32'h0000_0000;
        sp_ovf_w = 1'b0;
        if (exp_w == 8'd0) begin
            sp_res_w = 32'h0000_0000;
        end else if (exp_w == 8'hFF) begin
            sp_ovf_w = 1'b1;
            sp_res_w = (frac_w != 23'd0 || !a[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end else if (exp_w >= 8'd158) begin
            if (a == 32'hCF00_0000) begin
                sp_res_w = 32'h8000_0000;
            end else begin
                sp_ovf_w = 1'b1;
                sp_res_w = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else if (exp_w <= 8'd125) begin
            sp_res_w = 32'h0000_0000;
        end else begin
            sp_w = 1'b0;
        end
    end

    assign k_w = (exp_w > 8'd150) ? 5'(exp_w - 8'd150) : 5'(8'd150 - exp_w);

    // One-bit steps unrolled STEP times; bits past the remaining count are left untouched.
    always_comb begin
        sh_mag_w    = mag_q;
        sh_guard_w  = guard_q;
        sh_sticky_w = sticky_q;
        for (int i = 0; i < STEP; i++) begin
            if (5'(i) < rem_q) begin
                if (left_q) begin
                    sh_mag_w = {sh_mag_w[30:0], 1'b0};
                end else begin
                    sh_sticky_w = sh_sticky_w | sh_guard_w;
                    sh_guard_w  = sh_mag_w[0];
                    sh_mag_w    = {1'b0, sh_mag_w[31:1]};
                end
            end
        end
    end

    assign amt_w     = (rem_q < STEP5) ? rem_q : STEP5;
    assign rnd_mag_w = mag_q + {31'd0, guard_q & (sticky_q | mag_q[0])};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_w) begin
                    if (sp_w)                state_d = OUT;
                    else if (k_w == 5'd0)    state_d = ROUND;
                    else                     state_d = SHIFT;
                end
            end
            SHIFT:   if (rem_q <= STEP5) state_d = ROUND;
            ROUND:   state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == OUT);
        res       = res_q;
        ovf       = ovf_q;
    end

    always_comb begin
        sign_d   = sign_q;
        mag_d    = mag_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        rem_d    = rem_q;
        left_d   = left_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept_w) begin
                    sign_d   = a[31];
                    mag_d    = {8'd0, 1'b1, frac_w};
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                    rem_d    = k_w;
                    left_d   = (exp_w > 8'd150);
                    if (sp_w) begin
                        res_d = sp_res_w;
                        ovf_d = sp_ovf_w;
                    end
                end
            end
            SHIFT: begin
                mag_d    = sh_mag_w;
                guard_d  = sh_guard_w;
                sticky_d = sh_sticky_w;
                rem_d    = rem_q - amt_w;
            end
            ROUND: begin
                res_d = sign_q ? -rnd_mag_w : rnd_mag_w;
                ovf_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sign_q   <= 1'b0;
            mag_q    <= 32'd0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            rem_q    <= 5'd0;
            left_q   <= 1'b0;
            res_q    <= 32'd0;
            ovf_q    <= 1'b0;
        end else begin
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            rem_q    <= rem_d;
            left_q   <= left_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ftoi_seq.sv
// tb/tb_ftoi_seq.sv - scoreboard bench for ftoi_seq with a real-arithmetic reference model
module tb_ftoi_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        in_valid, in_ready, out_valid, out_ready, ovf;
    logic [31:0] a, res;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, ovf8;
    logic [31:0] a8, res8;

    ftoi_seq #(.STEP(1)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .a(a),
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .ovf(ovf)
    );

    ftoi_seq #(.STEP(8)) u_dut8 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8),
        .out_valid(out_valid8), .out_ready(out_ready8), .res(res8), .ovf(ovf8)
    );

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   hs_cnt = 0;
    int   rdy_mode = 1;
    bit   shown = 1'b0;
    bit   hs_prev = 1'b0;
    exp_t sb[$];
    exp_t cur;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Value of the float as an exact real, rounded half-to-even, then range-checked.
    function automatic logic [32:0] model(input logic [31:0] v);
        logic [7:0] e;
        real        x, r;
        int         sh, ri;
        e = v[30:23];
        if (e == 8'hFF)
            return (v[22:0] != 23'd0 || !v[31]) ? {1'b1, 32'h7FFF_FFFF} : {1'b1, 32'h8000_0000};
        x  = (e == 8'd0) ? real'(v[22:0]) : real'(v[22:0]) + 8388608.0;
        sh = (e == 8'd0) ? -149 : int'(e) - 150;
        for (int i = 0; i < sh; i++) x = x * 2.0;
        for (int i = 0; i < -sh; i++) x = x / 2.0;
        if (x >= 2147483648.0) begin
            if (v[31] && x == 2147483648.0) return {1'b0, 32'h8000_0000};
            return {1'b1, v[31] ? 32'h8000_0000 : 32'h7FFF_FFFF};
        end
        r = $floor(x);
        if ((x - r > 0.5) || (x - r == 0.5 && ($rtoi(r) % 2) == 1)) r = r + 1.0;
        ri = $rtoi(r);
        return {1'b0, v[31] ? 32'(-ri) : 32'(ri)};
    endfunction

    function automatic int lat_of(input logic [31:0] v, input int step);
        int e, k;
        e = int'(v[30:23]);
        if (e == 0 || e == 255 || e >= 158 || e <= 125) return 1;
        k = (e > 150) ? e - 150 : 150 - e;
        if (k == 0) return 2;
        return 2 + (k + step - 1) / step;
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: v[30:23] = 8'($urandom_range(120, 160));
            2: v[30:23] = 8'($urandom_range(126, 152));
            default: begin
                v[30:23] = 8'($urandom_range(126, 150));
                v[7:0]   = 8'd0;
            end
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        #2;
        case (rdy_mode)
            0:       out_ready = 1'($urandom_range(0, 1));
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    always @(posedge clk) begin
        exp_t        e;
        logic [32:0] m;
        if (rstn) begin
            if (in_valid && in_ready) begin
                m     = model(a);
                e.res = m[31:0];
                e.ovf = m[32];
                e.lat = lat_of(a, 1);
                e.acc = cyc;
                sb.push_back(e);
                acc_cnt++;
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                shown   = 1'b0;
                hs_prev = 1'b1;
            end else begin
                hs_prev = 1'b0;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (hs_prev) begin
                chk("in_ready_after_hs", 32'(in_ready), 32'd1);
                chk("out_valid_after_hs", 32'(out_valid), 32'd0);
            end
            if (out_valid) begin
                chk("in_ready_busy", 32'(in_ready), 32'd0);
                if (!shown) begin
                    shown = 1'b1;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: got res %h with no pending conversion", res);
                        cur.res = res;
                        cur.ovf = ovf;
                    end else begin
                        cur = sb.pop_front();
                        chk("res", res, cur.res);
                        chk("ovf", 32'(ovf), 32'(cur.ovf));
                        chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                    end
                end else begin
                    chk("res_hold", res, cur.res);
                    chk("ovf_hold", 32'(ovf), 32'(cur.ovf));
                end
            end
        end
    end

    task automatic send(input logic [31:0] v);
        int t;
        int h;
        @(negedge clk);
        in_valid = 1'b1;
        a        = v;
        t        = 0;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got no in_ready expected accept of %h", v);
        end
        h = hs_cnt;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        t        = 0;
        while (hs_cnt == h && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (t >= 500) begin
            n_cmp++; n_bad++;
            $display("FAIL result_timeout: got no handshake expected result for %h", v);
        end
    endtask

    task automatic run8(input logic [31:0] v);
        int          t;
        logic [32:0] m;
        @(negedge clk);
        in_valid8 = 1'b1;
        a8        = v;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        a8        = $urandom;
        t         = 1;
        while (!out_valid8 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        m = model(v);
        chk("step8_res", res8, m[31:0]);
        chk("step8_ovf", 32'(ovf8), 32'(m[32]));
        chk("step8_latency", 32'(t), 32'(lat_of(v, 8)));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] dir_vec [15] = '{
        32'h40490FDB, 32'h3FC00000, 32'h40200000, 32'hC0200000, 32'h3F000000,
        32'h3F400000, 32'h3EFFFFFF, 32'h4B7FFFFF, 32'h4EFFFFFF, 32'h4F000000,
        32'hCF000000, 32'hFF800000, 32'h7FC00000, 32'h00000001, 32'h80000000
    };

    initial begin
        int t;
        int ac0;
        rstn       = 1'b0;
        in_valid   = 1'b0;
        a          = 32'd0;
        in_valid8  = 1'b0;
        a8         = 32'd0;
        out_ready8 = 1'b1;
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_res", res, 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rstn = 1'b1;

        rdy_mode = 1;
        foreach (dir_vec[i]) send(dir_vec[i]);

        rdy_mode = 0;
        for (int i = 0; i < 150; i++) send(rand_float());

        // Backpressure: in_valid stays high with a changing while the result is held.
        rdy_mode = 1;
        send(32'h41200000);
        @(negedge clk);
        rdy_mode = 2;
        in_valid = 1'b1;
        a        = 32'h3FC00000;
        ac0      = acc_cnt;
        t        = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            a = $urandom;
            t++;
        end
        repeat (3) begin
            @(negedge clk);
            a = $urandom;
        end
        rdy_mode = 1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("single_accept", 32'(acc_cnt - ac0), 32'd1);
        chk("bp_queue_empty", 32'(sb.size()), 32'd0);

        // Reset in the middle of a long right shift.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h40490FDB;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_res", res, 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        shown = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        send(32'h41200000);

        foreach (dir_vec[i]) run8(dir_vec[i]);
        for (int i = 0; i < 20; i++) run8(rand_float());

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
